decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode stage of the 32-bit ARM-subset pipeline; sits directly upstream of the register file.
- Takes a fetched instruction word and produces registered control and register-address outputs (in1, in2, wa, we, ib, bv) plus ALU, memory and immediate control for execute.
- Owns three pipeline behaviours:
  - valid/ready backpressure;
  - single-bubble load-use interlock;
  - squash of the fetch slots in a taken branch's shadow.

Parameters:
- WORD, 4, bytes per data word.
- WIDTH, 8, bits per byte.
- ADDR_WIDTH, 4, register address width (16 registers, r15 = PC).
- SHADOW, 2, number of fetched instructions discarded after a taken branch.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  kill the output register and any pending squash.
- in_valid  in  1  instr is valid.
- in_ready  out  1  stage accepts instr this cycle.
- instr  in  WORD*WIDTH  instruction word.
- flags  in  4  N,Z,C,V; sampled at acceptance.
- out_valid  out  1  decoded outputs valid.
- out_ready  in  1  downstream accepts this cycle.
- in1  out  ADDR_WIDTH  Rn.
- in2  out  ADDR_WIDTH  Rm (store: Rd).
- wa  out  ADDR_WIDTH  Rd.
- we  out  1  register write enable.
- ib  out  1  taken branch.
- bv  out  WORD*WIDTH  branch offset.
- alu_op  out  4  bits[24:21].
- use_imm  out  1  operand 2 is the immediate.
- imm  out  WORD*WIDTH  zero-extended imm8 (dp) or imm12 (ld/st).
- is_load  out  1  load.
- is_store  out  1  store.
- is_byte  out  1  byte access (B bit).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid=0, squash_cnt=0;
  - all control outputs 0, all addresses 0, bv=0, imm=0.
- Latency: one cycle. A word accepted at edge k appears on the outputs after edge k.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~hazard.
  - Accept = in_valid & in_ready.
  - If no accept and (out_ready | ~out_valid), then out_valid<=0.
- Instruction classes, by bits[27:25]:
  - 00x = data-processing:
    - in1 = [19:16], in2 = [3:0], wa = [15:12], use_imm = bit 25.
    - we = 1, except for CMP/CMN/TST/TEQ (alu_op 10xx), where we = 0.
  - 01x = load/store:
    - use_imm = ~bit 25, is_byte = bit 22.
    - L=1: is_load = 1, we = 1.
    - L=0: is_store = 1, in2 = Rd, we = 0.
  - 101 = branch:
    - ib = 1.
    - bv = sign_extend(instr[23:0]) << 2, truncated to WORD*WIDTH bits.
  - Any other class: decoded as a NOP (all enables 0, out_valid=1).
- Condition (bits[31:28]):
  - Evaluated against the flags sampled at acceptance, using standard ARM semantics (EQ..LE).
  - AL = true; 1111 = never.
  - Condition false: the instruction is passed through with we = ib = is_load = is_store = 0.
- Load-use hazard:
  - hazard = out_valid & is_load & we & in_valid & (wa matches a source the incoming instruction actually reads: Rn, Rm, or store Rd).
  - While hazard=1: in_ready=0, and on an out_ready edge out_valid<=0. This inserts exactly one bubble.
  - Next cycle the load is gone, so hazard clears.
- Branch shadow:
  - When a taken branch is accepted, squash_cnt<=SHADOW.
  - While squash_cnt>0, each accepted word is dropped (out_valid<=0) and squash_cnt decrements.
  - Accepts inside the shadow never re-arm the counter.
- flush:
  - Highest priority after reset: out_valid<=0, squash_cnt<=0.
  - The input is not accepted (in_ready=0 while flush=1).
- Simultaneous out_ready and accept: the new word replaces the old one in the same edge (full throughput, no bubble).
- Reset mid-stream: all state is discarded, with no partial outputs.

Decomposition:
- Package cpu_pkg holds:
  - cond_e (4-bit ARM conditions);
  - alu_op_e (16 data-processing opcodes);
  - iclass_e (DP, LDST, BR, UNDEF);
  - localparam PC_REG = 4'd15.
- Sub-module cond_check (combinational): inputs cond[3:0] and flags[3:0]; output pass.

Test Plan:
- Reset, then release with in_valid=0 -> out_valid=0, we=0, ib=0, bv=0 for 3 cycles.
- ADD r1,r2,r3 (0xE0821003), flags=0, out_ready=1 -> next cycle out_valid=1, in1=2, in2=3, wa=1, we=1, alu_op=4'b0100, use_imm=0.
- Branch sequence:
  - B +8 (0xEAFFFFFE variant 0xEA000002) -> ib=1, bv=0x00000008.
  - The next two accepted words -> out_valid=0.
  - The third -> out_valid=1.
  - 0xEAFFFFFE -> bv=0xFFFFFFF8.
- BEQ (0x0A000002) with Z=0 -> out_valid=1, ib=0, we=0, and no squash of following words.
- LDR r1,[r2] (0xE5921000) then ADD r3,r1,r1 (0xE0813001), out_ready=1:
  - LDR output: is_load=1, wa=1.
  - Next cycle: out_valid=0 and in_ready=0.
  - Cycle after: the ADD appears with in1=1, in2=1.
- Backpressure: hold out_ready=0 for 4 cycles with the ADD loaded -> outputs unchanged and in_ready=0. Assert flush for 1 cycle -> out_valid=0 next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the ARM-subset pipeline: condition codes, ALU opcodes,
// instruction classes and the instruction-class decode helper.
package cpu_pkg;

   typedef enum logic [3:0] {
      C_EQ, C_NE, C_CS, C_CC, C_MI, C_PL, C_VS, C_VC,
      C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
   } cond_e;

   typedef enum logic [3:0] {
      OP_AND, OP_EOR, OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC,
      OP_TST, OP_TEQ, OP_CMP, OP_CMN, OP_ORR, OP_MOV, OP_BIC, OP_MVN
   } alu_op_e;

   typedef enum logic [1:0] {IC_DP, IC_LDST, IC_BR, IC_UNDEF} iclass_e;

   localparam logic [3:0] PC_REG = 4'd15;

   function automatic iclass_e classify(input logic [2:0] f);
      case (f)
         3'b000, 3'b001: return IC_DP;
         3'b010, 3'b011: return IC_LDST;
         3'b101:         return IC_BR;
         default:        return IC_UNDEF;
      endcase
   endfunction

   // TST/TEQ/CMP/CMN only set flags and never write a register.
   function automatic logic is_test_op(input alu_op_e op);
      return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
   endfunction

endpackage

// File: rtl/decode_stage_cond_check.sv
// Combinational ARM condition evaluation against NZCV flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       pass
);

   logic n, z, c, v;

   always_comb begin
      {n, z, c, v} = flags;
      unique case (cond_e'(cond))
         C_EQ: pass = z;
         C_NE: pass = ~z;
         C_CS: pass = c;
         C_CC: pass = ~c;
         C_MI: pass = n;
         C_PL: pass = ~n;
         C_VS: pass = v;
         C_VC: pass = ~v;
         C_HI: pass = c & ~z;
         C_LS: pass = ~c | z;
         C_GE: pass = (n == v);
         C_LT: pass = (n != v);
         C_GT: pass = ~z & (n == v);
         C_LE: pass = z | (n != v);
         C_AL: pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: registered decode with valid/ready flow control,
// a one-bubble load-use interlock and squash of the taken-branch shadow.
module decode_stage
   import cpu_pkg::*;
#(
   parameter int WORD       = 4,
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int SHADOW     = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WORD*WIDTH-1:0]  instr,
   input  logic [3:0]             flags,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ADDR_WIDTH-1:0]  in1,
   output logic [ADDR_WIDTH-1:0]  in2,
   output logic [ADDR_WIDTH-1:0]  wa,
   output logic                   we,
   output logic                   ib,
   output logic [WORD*WIDTH-1:0]  bv,
   output logic [3:0]             alu_op,
   output logic                   use_imm,
   output logic [WORD*WIDTH-1:0]  imm,
   output logic                   is_load,
   output logic                   is_store,
   output logic                   is_byte
);

   localparam int DW  = WORD * WIDTH;
   localparam int SCW = $clog2(SHADOW + 1);

   function automatic logic signed [DW-1:0] br_offset(input logic [DW-1:0] w);
      logic signed [DW-1:0] ext;
      ext = {{(DW-24){w[23]}}, w[23:0]};
      return ext <<< 2;
   endfunction

   iclass_e               cls;
   logic                  pass;
   logic                  rd_rn, rd_rm, rd_rd;
   logic                  hazard, accept;
   logic [ADDR_WIDTH-1:0] rn, rm, rd;

   logic [ADDR_WIDTH-1:0] in1_d, in2_d, wa_d, in1_q, in2_q, wa_q;
   logic                  we_d, ib_d, use_imm_d, ld_d, st_d, byte_d;
   logic                  we_q, ib_q, use_imm_q, ld_q, st_q, byte_q;
   logic [DW-1:0]         bv_d, imm_d, bv_q, imm_q;
   logic [3:0]            alu_d, alu_q;
   logic                  out_valid_q;
   logic [SCW-1:0]        squash_q;

   cond_check u_cond (
      .cond  (instr[31:28]),
      .flags (flags),
      .pass  (pass)
   );

   assign rn  = ADDR_WIDTH'(instr[19:16]);
   assign rd  = ADDR_WIDTH'(instr[15:12]);
   assign rm  = ADDR_WIDTH'(instr[3:0]);
   assign cls = classify(instr[27:25]);

   always_comb begin
      in1_d     = '0;
      in2_d     = '0;
      wa_d      = '0;
      we_d      = 1'b0;
      ib_d      = 1'b0;
      bv_d      = '0;
      alu_d     = '0;
      use_imm_d = 1'b0;
      imm_d     = '0;
      ld_d      = 1'b0;
      st_d      = 1'b0;
      byte_d    = 1'b0;
      rd_rn     = 1'b0;
      rd_rm     = 1'b0;
      rd_rd     = 1'b0;
      unique case (cls)
         IC_DP: begin
            in1_d     = rn;
            in2_d     = rm;
            wa_d      = rd;
            alu_d     = instr[24:21];
            use_imm_d = instr[25];
            imm_d     = DW'(instr[7:0]);
            we_d      = ~is_test_op(alu_op_e'(instr[24:21]));
            rd_rn     = 1'b1;
            rd_rm     = ~instr[25];
         end
         IC_LDST: begin
            in1_d     = rn;
            wa_d      = rd;
            use_imm_d = ~instr[25];
            byte_d    = instr[22];
            imm_d     = DW'(instr[11:0]);
            rd_rn     = 1'b1;
            rd_rm     = instr[25];
            if (instr[20]) begin
               ld_d  = 1'b1;
               we_d  = 1'b1;
               in2_d = rm;
            end else begin
               st_d  = 1'b1;
               in2_d = rd;
               rd_rd = 1'b1;
            end
         end
         IC_BR: begin
            ib_d = 1'b1;
            bv_d = br_offset(instr);
         end
         default: ;
      endcase
      // A failed condition still occupies a slot but has no side effects.
      if (!pass) begin
         we_d = 1'b0;
         ib_d = 1'b0;
         ld_d = 1'b0;
         st_d = 1'b0;
      end
   end

   assign hazard = out_valid_q & ld_q & we_q & in_valid &
                   ((rd_rn & (wa_q == rn)) | (rd_rm & (wa_q == rm)) | (rd_rd & (wa_q == rd)));
   assign in_ready = (~out_valid_q | out_ready) & ~hazard & ~flush;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         squash_q    <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         wa_q        <= '0;
         we_q        <= 1'b0;
         ib_q        <= 1'b0;
         bv_q        <= '0;
         alu_q       <= '0;
         use_imm_q   <= 1'b0;
         imm_q       <= '0;
         ld_q        <= 1'b0;
         st_q        <= 1'b0;
         byte_q      <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         squash_q    <= '0;
      end else if (accept) begin
         if (squash_q != '0) begin
            out_valid_q <= 1'b0;
            squash_q    <= squash_q - SCW'(1);
         end else begin
            out_valid_q <= 1'b1;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            wa_q        <= wa_d;
            we_q        <= we_d;
            ib_q        <= ib_d;
            bv_q        <= bv_d;
            alu_q       <= alu_d;
            use_imm_q   <= use_imm_d;
            imm_q       <= imm_d;
            ld_q        <= ld_d;
            st_q        <= st_d;
            byte_q      <= byte_d;
            if (ib_d) squash_q <= SCW'(SHADOW);
         end
      end else if (out_ready | ~out_valid_q) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign in1       = in1_q;
   assign in2       = in2_q;
   assign wa        = wa_q;
   assign we        = we_q;
   assign ib        = ib_q;
   assign bv        = bv_q;
   assign alu_op    = alu_q;
   assign use_imm   = use_imm_q;
   assign imm       = imm_q;
   assign is_load   = ld_q;
   assign is_store  = st_q;
   assign is_byte   = byte_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected decodes are queued on acceptance
// and compared whenever the stage presents a valid output.
module tb_decode_stage;

   typedef struct packed {
      logic [3:0]  in1, in2, wa;
      logic        we, ib;
      logic [31:0] bv;
      logic [3:0]  alu;
      logic        use_imm;
      logic [31:0] imm;
      logic        ld, st, byt;
   } dec_t;

   typedef struct packed {
      dec_t e;
      dec_t m;
   } item_t;

   localparam int SHADOW = 2;

   logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] instr = '0;
   logic [3:0]  flags = '0;
   logic        in_ready, out_valid, we, ib, use_imm, is_load, is_store, is_byte;
   logic [3:0]  in1, in2, wa, alu_op;
   logic [31:0] bv, imm;

   int    errors = 0, checks = 0, sq = 0;
   item_t q[$];
   item_t pend;
   bit    last_acc;

   decode_stage #(.WORD(4), .WIDTH(8), .ADDR_WIDTH(4), .SHADOW(SHADOW)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .flags(flags), .out_valid(out_valid), .out_ready(out_ready),
      .in1(in1), .in2(in2), .wa(wa), .we(we), .ib(ib), .bv(bv), .alu_op(alu_op),
      .use_imm(use_imm), .imm(imm), .is_load(is_load), .is_store(is_store), .is_byte(is_byte)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic item_t dp(input logic [3:0] rn, rm, rd, input logic w,
                                input logic [3:0] op, input logic ui, input logic [7:0] i8);
      item_t it;
      it = '0;
      it.e.in1 = rn; it.e.in2 = rm; it.e.wa = rd; it.e.we = w;
      it.e.alu = op; it.e.use_imm = ui; it.e.imm = {24'h0, i8};
      it.m.in1 = '1; it.m.in2 = '1; it.m.wa = '1; it.m.we = '1; it.m.ib = '1;
      it.m.alu = '1; it.m.use_imm = '1; it.m.imm = '1; it.m.ld = '1; it.m.st = '1;
      return it;
   endfunction

   function automatic item_t ls(input logic [3:0] rn, r2, rd, input logic l, s, w, ui, b,
                                input logic [11:0] i12);
      item_t it;
      it = '0;
      it.e.in1 = rn; it.e.in2 = r2; it.e.wa = rd; it.e.ld = l; it.e.st = s; it.e.we = w;
      it.e.use_imm = ui; it.e.byt = b; it.e.imm = {20'h0, i12};
      it.m = '1;
      it.m.alu = '0; it.m.bv = '0;
      return it;
   endfunction

   function automatic item_t br(input logic taken, input logic [31:0] off);
      item_t it;
      it = '0;
      it.e.ib = taken; it.e.bv = off;
      it.m.ib = '1; it.m.bv = '1; it.m.we = '1; it.m.ld = '1; it.m.st = '1;
      return it;
   endfunction

   function automatic item_t nop();
      item_t it;
      it = '0;
      it.m.ib = '1; it.m.we = '1; it.m.ld = '1; it.m.st = '1;
      return it;
   endfunction

   task automatic tick();
      bit acc, cons;
      dec_t obs;
      @(negedge clk);
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      @(posedge clk);
      #1;
      last_acc = acc;
      if (!rst_n || flush) begin
         q.delete();
         sq = 0;
      end else begin
         if (cons && q.size() > 0) q.delete(0);
         if (acc) begin
            if (sq > 0) sq--;
            else begin
               q.push_back(pend);
               if (pend.e.ib) sq = SHADOW;
            end
         end
      end
      chk("qsync", out_valid, q.size() != 0);
      if (out_valid && q.size() > 0) begin
         obs = '{in1, in2, wa, we, ib, bv, alu_op, use_imm, imm, is_load, is_store, is_byte};
         chk("decode", 128'(obs & q[0].m), 128'(q[0].e & q[0].m));
      end
   endtask

   task automatic drive(input logic [31:0] w, input logic [3:0] f, input item_t it);
      instr = w; flags = f; in_valid = 1'b1; pend = it;
   endtask

   task automatic send(input logic [31:0] w, input logic [3:0] f, input item_t it);
      drive(w, f, it);
      last_acc = 1'b0;
      for (int n = 0; n < 20 && !last_acc; n++) tick();
      chk("accept", last_acc, 1'b1);
   endtask

   initial begin
      // reset state
      tick(); tick();
      chk("rst_valid", out_valid, 0); chk("rst_we", we, 0); chk("rst_ib", ib, 0);
      chk("rst_bv", bv, 0); chk("rst_imm", imm, 0); chk("rst_wa", wa, 0);
      chk("rst_in1", in1, 0); chk("rst_load", is_load, 0);
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         chk("idle_valid", out_valid, 0); chk("idle_we", we, 0);
         chk("idle_ib", ib, 0); chk("idle_bv", bv, 0);
      end

      // ADD r1,r2,r3
      out_ready = 1'b1;
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      chk("add_valid", out_valid, 1); chk("add_alu", alu_op, 4'b0100);

      // taken branch and its two-slot shadow
      send(32'hEA000002, 4'h0, br(1'b1, 32'h0000_0008));
      chk("b_ib", ib, 1); chk("b_bv", bv, 32'h0000_0008);
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      chk("shadow1", out_valid, 0);
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      chk("shadow2", out_valid, 0);
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      chk("shadow_end", out_valid, 1);
      send(32'hEAFFFFFE, 4'h0, br(1'b1, 32'hFFFF_FFF8));
      chk("bneg_bv", bv, 32'hFFFF_FFF8);
      send(32'hE8000000, 4'h0, nop());
      send(32'hE8000000, 4'h0, nop());
      chk("shadow_neg", out_valid, 0);
      send(32'hE8000000, 4'h0, nop());
      chk("nop_valid", out_valid, 1); chk("nop_we", we, 0);

      // conditions
      send(32'h0A000002, 4'b0000, br(1'b0, 32'h0000_0008));
      chk("beq_valid", out_valid, 1); chk("beq_ib", ib, 0);
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      chk("beq_noshadow", out_valid, 1);
      send(32'hA0821003, 4'b1001, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      send(32'hB0821003, 4'b1001, dp(4'd2, 4'd3, 4'd1, 1'b0, 4'b0100, 1'b0, 8'h03));
      send(32'hE3520005, 4'h0, dp(4'd2, 4'd5, 4'd0, 1'b0, 4'b1010, 1'b1, 8'h05));
      send(32'hE5C54012, 4'h0, ls(4'd5, 4'd4, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h012));

      // load-use interlock
      send(32'hE5921000, 4'h0, ls(4'd2, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000));
      chk("ldr_load", is_load, 1); chk("ldr_wa", wa, 1);
      drive(32'hE0813001, 4'h0, dp(4'd1, 4'd1, 4'd3, 1'b1, 4'b0100, 1'b0, 8'h01));
      #1;
      chk("hazard_ready", in_ready, 0);
      tick();
      chk("bubble_valid", out_valid, 0); chk("bubble_noacc", last_acc, 0);
      tick();
      chk("lu_accept", last_acc, 1); chk("lu_in1", in1, 1); chk("lu_in2", in2, 1);

      // backpressure then flush
      out_ready = 1'b0;
      drive(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      repeat (4) begin
         tick();
         chk("bp_valid", out_valid, 1); chk("bp_ready", in_ready, 0); chk("bp_wa", wa, 3);
      end
      out_ready = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_ready", in_ready, 0);
      tick();
      flush = 1'b0;
      in_valid = 1'b0;
      chk("flush_valid", out_valid, 0);

      // reset mid-stream
      send(32'hE0821003, 4'h0, dp(4'd2, 4'd3, 4'd1, 1'b1, 4'b0100, 1'b0, 8'h03));
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      chk("pre_rst_valid", out_valid, 1);
      rst_n = 1'b0;
      tick();
      chk("mid_rst_valid", out_valid, 0); chk("mid_rst_wa", wa, 0); chk("mid_rst_we", we, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
